pwm_sample_scheduler: RTL and testbench
=======================================

# pwm_sample_scheduler

Frame-synchronous sample scheduler for the PWM audio output stage. It buffers signed samples from the upstream filter/decimator chain in a small FIFO. It delivers exactly one sample per PWM frame of 2^DATA_WIDTH clocks, timed so the PWM modulator captures each sample before its compare-register reload. It also handles prefill, underrun recovery and enable/disable, so the modulator always sees either valid audio or midscale silence (0).

## Interface

Parameters:
- DATA_WIDTH, 12, sample width; the frame length is 2^DATA_WIDTH clocks, matching the modulator counter.
- FIFO_DEPTH, 8, sample buffer depth; power of two, at least 4.
- UNDERRUN_CNT_WIDTH, 16, width of the underrun counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high. Must be released on the same edge as the modulator reset to keep frame alignment.
- enable  input  1  playback enable.
- in_valid  input  1  upstream sample valid.
- in_data  input  DATA_WIDTH (signed)  upstream sample.
- in_ready  output  1  sample accepted when in_valid && in_ready at a rising edge.
- pwm_data_valid  output  1  one-cycle pulse, connects to the modulator data_valid.
- pwm_data  output  DATA_WIDTH (signed)  sample to the modulator, held between pulses.
- frame_strobe  output  1  one-cycle pulse at the last clock of each frame.
- underrun  output  1  one-cycle pulse when a RUN frame finds the FIFO empty.
- underrun_count  output  UNDERRUN_CNT_WIDTH  saturating underrun total.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.

## Operation

- **Frame counter:** free-running, DATA_WIDTH bits, 0 to 2^DATA_WIDTH−1, wraps to 0. It is independent of state and cleared only by rst.
- **Tick:** frame counter == 2^DATA_WIDTH−2. All state decisions and FIFO pops happen only on a tick.
- **States:** IDLE, FILL, RUN.
- **IDLE:**
  - in_ready = 0, FIFO held empty.
  - Each tick issues pwm_data = 0.
  - enable = 1 → FILL on the next clock; no tick is needed.
- **FILL:**
  - in_ready = (fifo_level < FIFO_DEPTH).
  - Each tick issues 0, with no pop.
  - At a tick with fifo_level ≥ FIFO_DEPTH/2 → RUN; that tick still issues 0.
- **RUN:** at each tick:
  - fifo_level > 0: pop the head, pwm_data = head.
  - fifo_level = 0: pwm_data = 0, underrun pulse, underrun_count += 1 (saturating at all-ones), → FILL.
- **enable = 0** in FILL or RUN: at the next tick, issue 0, flush the FIFO (fifo_level = 0 on the following clock), → IDLE. Pushes accepted before that tick are discarded by the flush.
- **Simultaneous push and pop at a tick:** both take effect, level unchanged. A push when fifo_level == FIFO_DEPTH is impossible because in_ready = 0; in_valid is ignored in that case.
- **FIFO order:** strict FIFO; samples are passed through unmodified.
- **in_ready:** decoded combinationally from registered state and level only; no combinational path from in_valid.

## Timing

- **Reset values:**
  - in_ready 0, pwm_data_valid 0, pwm_data 0, frame_strobe 0, underrun 0.
  - underrun_count 0, fifo_level 0.
  - State IDLE, frame counter 0.
- **pwm_data_valid** is registered and asserted during the clock where the frame counter == 2^DATA_WIDTH−1. The modulator therefore latches it before its reload at counter all-ones, and the sample takes effect for the next frame.
- **pwm_data** updates on the same edge that raises pwm_data_valid.
- **frame_strobe** is coincident with pwm_data_valid.
- **underrun** is coincident with the pwm_data_valid of the zero-issuing frame.
- **fifo_level** reflects a push or pop one clock after the accepting edge.
- **Reset mid-operation:** everything returns to reset values on the next edge. FIFO contents are lost and underrun_count is cleared.
- **Pulse rate:** pwm_data_valid pulses exactly once per frame in every state, never more.

## Test plan

Use DATA_WIDTH=4 (16-clock frame) and FIFO_DEPTH=8.
- **Reset:** rst for 3 cycles → all outputs 0. pwm_data_valid pulses with pwm_data=0 at cycles 15, 31, 47 after release; state stays IDLE with enable=0.
- **Prefill/run:**
  - Set enable=1 and push 4 samples {5, −3, 7, −8}.
  - The next tick issues 0 and enters RUN.
  - The following four pulses carry 5, −3, 7, −8 in order.
- **Underrun:** continuing from prefill/run with no further pushes:
  - The fifth pulse carries 0, with underrun high in the same cycle and underrun_count = 1.
  - State returns to FILL.
  - No audio until 4 more samples are buffered.
- **Full/simultaneous:**
  - Hold in_valid=1 until fifo_level=8 → in_ready=0 and no push.
  - At the next RUN tick, a pop occurs and in_ready rises. A push on that tick leaves level 8.
- **Disable:**
  - Drop enable in RUN with level 6 → the next tick issues 0, fifo_level=0 one clock later, in_ready=0, state IDLE.
  - Raise enable again → FILL.
- **Reset mid-run:** assert rst while level=5 and underrun_count=3 → all outputs and the frame counter return to 0. The first pulse after release is at cycle 15.

Source files
------------

// File: rtl/pwm_sample_scheduler.sv
// pwm_sample_scheduler
//
// Frame-synchronous sample scheduler feeding the PWM modulator. Signed
// samples from the upstream filter/decimator chain are buffered in a small
// FIFO. Exactly one sample is issued per PWM frame of 2^DATA_WIDTH clocks,
// one clock before the modulator's compare-register reload. Prefill,
// underrun recovery and enable/disable are handled here, so the modulator
// only ever sees valid audio or midscale silence (0).
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset; release together with the
//                  modulator reset so the frame counters stay aligned
//   enable         playback enable
//   in_valid       upstream sample valid
//   in_data        upstream signed sample
//   in_ready       sample accepted when in_valid && in_ready at a rising edge
//   pwm_data_valid one-cycle pulse per frame, to the modulator data_valid
//   pwm_data       signed sample to the modulator, held between pulses
//   frame_strobe   one-cycle pulse in the last clock of every frame
//   underrun       one-cycle pulse when a RUN frame finds the FIFO empty
//   underrun_count saturating total of underruns
//   fifo_level     current FIFO occupancy, 0..FIFO_DEPTH
module pwm_sample_scheduler #(
  parameter int DATA_WIDTH         = 12,
  parameter int FIFO_DEPTH         = 8,
  parameter int UNDERRUN_CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           in_valid,
  input  logic signed [DATA_WIDTH-1:0]   in_data,
  output logic                           in_ready,
  output logic                           pwm_data_valid,
  output logic signed [DATA_WIDTH-1:0]   pwm_data,
  output logic                           frame_strobe,
  output logic                           underrun,
  output logic [UNDERRUN_CNT_WIDTH-1:0]  underrun_count,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  // The decision point sits one clock before counter all-ones, so the
  // registered pulse lands in the all-ones clock, ahead of the reload.
  localparam logic [DATA_WIDTH-1:0] TICK_VAL  = {{(DATA_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [LW-1:0]         DEPTH_LVL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]         HALF_LVL  = LW'(FIFO_DEPTH / 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [UNDERRUN_CNT_WIDTH-1:0] sat_inc(
    input logic [UNDERRUN_CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + UNDERRUN_CNT_WIDTH'(1);
  endfunction

  // Control state
  state_e                          state_q, state_d;
  logic [DATA_WIDTH-1:0]           frame_cnt_q;
  logic [PW-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                   level_q, level_d;
  logic [UNDERRUN_CNT_WIDTH-1:0]   urun_cnt_q, urun_cnt_d;

  // Registered outputs
  logic                            pwm_vld_q;
  logic signed [DATA_WIDTH-1:0]    pwm_data_q;
  logic                            strobe_q;
  logic                            urun_q;

  // Sample storage (data only, never reset)
  logic signed [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];

  // Decoded per-cycle controls
  logic                            tick;
  logic                            push;
  logic                            pop;
  logic                            flush;
  logic                            urun_d;
  logic signed [DATA_WIDTH-1:0]    issue_d;

  assign tick = (frame_cnt_q == TICK_VAL);

  // in_ready depends only on registered state and level, never on in_valid.
  // A full FIFO therefore ignores in_valid.
  assign in_ready = (state_q != S_IDLE) && (level_q < DEPTH_LVL);
  assign push     = in_valid && in_ready;

  // Next-state decode: every state change other than IDLE -> FILL waits
  // for a tick.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    flush      = 1'b0;
    urun_d     = 1'b0;
    issue_d    = '0;
    urun_cnt_d = urun_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (tick) begin
          if (!enable) begin
            flush   = 1'b1;
            state_d = S_IDLE;
          end else if (level_q >= HALF_LVL) begin
            // Entry tick still issues silence; audio starts next frame.
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (tick) begin
          if (!enable) begin
            flush   = 1'b1;
            state_d = S_IDLE;
          end else if (level_q != '0) begin
            pop     = 1'b1;
            issue_d = mem_q[rd_ptr_q];
          end else begin
            urun_d     = 1'b1;
            urun_cnt_d = sat_inc(urun_cnt_q);
            state_d    = S_FILL;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer/level update. A flush overrides any push on the same
  // edge, so samples accepted before a disable are discarded.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      urun_cnt_q  <= '0;
      pwm_vld_q   <= 1'b0;
      pwm_data_q  <= '0;
      strobe_q    <= 1'b0;
      urun_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_q + DATA_WIDTH'(1);
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      urun_cnt_q  <= urun_cnt_d;
      pwm_vld_q   <= tick;
      strobe_q    <= tick;
      urun_q      <= urun_d;
      if (tick) begin
        pwm_data_q <= issue_d;
      end
    end
  end

  // Sample storage write
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign pwm_data_valid = pwm_vld_q;
  assign pwm_data       = pwm_data_q;
  assign frame_strobe   = strobe_q;
  assign underrun       = urun_q;
  assign underrun_count = urun_cnt_q;
  assign fifo_level     = level_q;

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Testbench for pwm_sample_scheduler with DATA_WIDTH=4 (16-clock frame)
// and FIFO_DEPTH=8. Expected pulse contents go into a scoreboard queue as
// stimulus is driven. A monitor checks pulse timing every cycle and pops
// the queue on each pulse; with the queue empty, a pulse must carry silence.
module tb_pwm_sample_scheduler;

  localparam int DW = 4;
  localparam int FD = 8;
  localparam int UW = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  enable = 1'b0;
  logic                  in_valid = 1'b0;
  logic signed [DW-1:0]  in_data = '0;
  logic                  in_ready;
  logic                  pwm_data_valid;
  logic signed [DW-1:0]  pwm_data;
  logic                  frame_strobe;
  logic                  underrun;
  logic [UW-1:0]         underrun_count;
  logic [$clog2(FD):0]   fifo_level;

  pwm_sample_scheduler #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD),
    .UNDERRUN_CNT_WIDTH(UW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .pwm_data_valid(pwm_data_valid),
    .pwm_data(pwm_data),
    .frame_strobe(frame_strobe),
    .underrun(underrun),
    .underrun_count(underrun_count),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] d;
    logic                 u;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   bcyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic signed [DW-1:0] d, input logic u);
    exp_t e;
    e.d = d;
    e.u = u;
    expq.push_back(e);
  endtask

  // Pulse monitor: the frame counter is cleared by a reset edge and then
  // counts edges, so the pulse is due whenever the count is 15 mod 16.
  always @(posedge clk) begin
    logic r;
    exp_t e;
    r = rst;
    #1;
    if (r) bcyc = 0;
    else   bcyc++;
    chk("valid_timing", 32'(pwm_data_valid), 32'(!r && (bcyc % 16 == 15)));
    chk("strobe_timing", 32'(frame_strobe), 32'(!r && (bcyc % 16 == 15)));
    if (pwm_data_valid) begin
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pulse_data", 32'(pwm_data), 32'(e.d));
        chk("pulse_underrun", 32'(underrun), 32'(e.u));
      end else begin
        chk("silence_data", 32'(pwm_data), 32'(0));
        chk("silence_underrun", 32'(underrun), 32'(0));
      end
    end else begin
      chk("underrun_offpulse", 32'(underrun), 32'(0));
    end
  end

  // Waits for the next pulse (bounded) and returns the number of edges waited.
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!pwm_data_valid && n < 40);
    chk("pulse_seen", 32'(pwm_data_valid), 32'(1));
  endtask

  // Pushes four samples right after a pulse, then expects: entry tick
  // silence, the four samples in order, then an underrun silence.
  task automatic run_burst(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                           input logic signed [DW-1:0] c, input logic signed [DW-1:0] d);
    logic signed [DW-1:0] v [4];
    int n;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_ready", 32'(in_ready), 32'(1));
      in_valid = 1'b1;
      in_data  = v[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("burst_level", 32'(fifo_level), 32'(4));
    enq(0, 1'b0);
    for (int i = 0; i < 4; i++) enq(v[i], 1'b0);
    enq(0, 1'b1);
    for (int i = 0; i < 6; i++) wait_pulse(n);
  endtask

  initial begin
    int n;
    logic signed [DW-1:0] fv [8];
    fv = '{4'sd1, 4'sd2, 4'sd3, 4'sd4, 4'sd5, 4'sd6, 4'sd7, -4'sd1};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_valid", 32'(pwm_data_valid), 32'(0));
    chk("rst_data", 32'(pwm_data), 32'(0));
    chk("rst_strobe", 32'(frame_strobe), 32'(0));
    chk("rst_underrun", 32'(underrun), 32'(0));
    chk("rst_ucount", 32'(underrun_count), 32'(0));
    chk("rst_level", 32'(fifo_level), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    wait_pulse(n);
    chk("first_pulse_cycle", 32'(n), 32'(15));
    wait_pulse(n);
    chk("second_pulse_gap", 32'(n), 32'(16));
    wait_pulse(n);
    chk("third_pulse_gap", 32'(n), 32'(16));
    chk("idle_in_ready", 32'(in_ready), 32'(0));

    // Prefill/run, then underrun
    @(negedge clk);
    enable = 1'b1;
    run_burst(4'sd5, -4'sd3, 4'sd7, -4'sd8);
    chk("ucount_1", 32'(underrun_count), 32'(1));
    chk("urun_level", 32'(fifo_level), 32'(0));
    chk("urun_fill_ready", 32'(in_ready), 32'(1));
    wait_pulse(n);
    wait_pulse(n);
    chk("ucount_hold", 32'(underrun_count), 32'(1));

    // Full FIFO and push alongside pop
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fill_ready", 32'(in_ready), 32'(1));
      in_valid = 1'b1;
      in_data  = fv[i];
    end
    @(negedge clk);
    in_data = -4'sd2;
    chk("full_ready", 32'(in_ready), 32'(0));
    chk("full_level", 32'(fifo_level), 32'(8));
    @(negedge clk);
    chk("full_no_push", 32'(fifo_level), 32'(8));
    enq(0, 1'b0);
    enq(fv[0], 1'b0);
    wait_pulse(n);
    wait_pulse(n);
    chk("pop_level", 32'(fifo_level), 32'(7));
    chk("pop_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    chk("refill_level", 32'(fifo_level), 32'(8));
    chk("refill_ready", 32'(in_ready), 32'(0));
    @(negedge clk);
    in_valid = 1'b0;
    enq(fv[1], 1'b0);
    enq(fv[2], 1'b0);
    wait_pulse(n);
    wait_pulse(n);
    chk("pre_disable_level", 32'(fifo_level), 32'(6));

    // Disable while running
    @(negedge clk);
    enable = 1'b0;
    enq(0, 1'b0);
    wait_pulse(n);
    chk("flush_level", 32'(fifo_level), 32'(0));
    chk("flush_ready", 32'(in_ready), 32'(0));
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("reenable_ready", 32'(in_ready), 32'(1));

    // Two more underruns, then reset with data buffered
    wait_pulse(n);
    run_burst(4'sd1, -4'sd1, 4'sd2, -4'sd2);
    chk("ucount_2", 32'(underrun_count), 32'(2));
    run_burst(4'sd3, -4'sd3, 4'sd4, -4'sd4);
    chk("ucount_3", 32'(underrun_count), 32'(3));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = fv[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("prerst_level", 32'(fifo_level), 32'(5));
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_level", 32'(fifo_level), 32'(0));
    chk("midrst_ucount", 32'(underrun_count), 32'(0));
    chk("midrst_ready", 32'(in_ready), 32'(0));
    chk("midrst_data", 32'(pwm_data), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    wait_pulse(n);
    chk("postrst_pulse_cycle", 32'(n), 32'(15));

    chk("scoreboard_drained", 32'(expq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
